// File: rtl/player_input_pkg.sv
// Shared definitions for the player input conditioning block: player
// count, choice width, default timing constants, FSM state encoding and
// the fixed-priority pick used by the turn arbiter.
package player_input_pkg;

  localparam int unsigned NUM_PLAYERS             = 6;
  localparam int unsigned CHOICE_W                = 3;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEFAULT_PULSE_CYCLES    = 4;

  // One bit per player, bit i belongs to player i+1.
  typedef logic [NUM_PLAYERS-1:0] player_vec_t;

  // Per-player turn FSM.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_PULSE    = 2'd2,
    ST_WAIT_REL = 2'd3
  } player_state_e;

  // Returns a one-hot vector marking the lowest set bit of req, or zero.
  function automatic player_vec_t lowest_one(input player_vec_t req);
    player_vec_t pick;
    pick = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (req[i] && (pick == '0)) begin
        pick[i] = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/debounce.sv
// One button channel: a two-flop synchronizer followed by a debouncer.
// The debounced level only follows the synchronized input after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive
// samples. 'rise' is a one-cycle strobe coincident with a 0->1 change of
// the debounced level.
module debounce
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned            CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             synced;

  assign synced = sync_q[1];

  // Two-flop synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  // Count consecutive disagreeing samples; the final one flips the level.
  // The counter restarts on any agreeing sample and never exceeds CNT_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (synced != level) begin
        if (cnt == CNT_LAST) begin
          level <= synced;
          rise  <= synced;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/player_input_cond.sv
// Player input conditioning: debounces six player buttons, arbitrates a
// single turn at a time, latches the player's choice switches one cycle
// ahead of a fixed-width player_clk pulse, and then waits for the button
// to be released before that player can request another turn.
module player_input_cond
  import player_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEFAULT_PULSE_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] btn,
  input  logic [2:0] sw_p1,
  input  logic [2:0] sw_p2,
  input  logic [2:0] sw_p3,
  input  logic [2:0] sw_p4,
  input  logic [2:0] sw_p5,
  input  logic [2:0] sw_p6,
  output logic [2:0] player1,
  output logic [2:0] player2,
  output logic [2:0] player3,
  output logic [2:0] player4,
  output logic [2:0] player5,
  output logic [2:0] player6,
  output logic [5:0] player_clk,
  output logic       busy
);

  localparam int unsigned       PCNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

  player_vec_t level;
  player_vec_t rise;
  player_vec_t idle;
  player_vec_t active;
  player_vec_t grant;

  logic [NUM_PLAYERS-1:0][CHOICE_W-1:0] sw_all;
  logic [NUM_PLAYERS-1:0][CHOICE_W-1:0] choice;

  assign sw_all = {sw_p6, sw_p5, sw_p4, sw_p3, sw_p2, sw_p1};

  assign player1 = choice[0];
  assign player2 = choice[1];
  assign player3 = choice[2];
  assign player4 = choice[3];
  assign player5 = choice[4];
  assign player6 = choice[5];

  assign busy = |active;

  // Turn arbiter: nothing is granted while a turn is in SETUP or PULSE;
  // otherwise the lowest-index idle player with a fresh press wins.
  always_comb begin
    grant = '0;
    if (!(|active)) begin
      grant = lowest_one(rise & idle);
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
    player_state_e         state;
    logic [PCNT_W-1:0]     pcnt;
    logic                  pulse_q;
    logic [CHOICE_W-1:0]   choice_q;

    debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (btn[i]),
      .level  (level[i]),
      .rise   (rise[i])
    );

    assign idle[i]       = (state == ST_IDLE);
    assign active[i]     = (state == ST_SETUP) || (state == ST_PULSE);
    assign choice[i]     = choice_q;
    assign player_clk[i] = pulse_q;

    // Per-player turn FSM. A press that loses arbitration or arrives while
    // another turn is running is parked in WAIT_REL, so it never pulses
    // and the player has to release and press again.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state    <= ST_IDLE;
        pcnt     <= '0;
        pulse_q  <= 1'b0;
        choice_q <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise[i]) begin
              if (grant[i]) begin
                state    <= ST_SETUP;
                choice_q <= sw_all[i];
              end else begin
                state <= ST_WAIT_REL;
              end
            end
          end
          ST_SETUP: begin
            state   <= ST_PULSE;
            pulse_q <= 1'b1;
            pcnt    <= '0;
          end
          ST_PULSE: begin
            if (pcnt == PCNT_LAST) begin
              state   <= ST_WAIT_REL;
              pulse_q <= 1'b0;
              pcnt    <= '0;
            end else begin
              pcnt <= pcnt + PCNT_W'(1);
            end
          end
          ST_WAIT_REL: begin
            if (!level[i]) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state   <= ST_IDLE;
            pulse_q <= 1'b0;
            pcnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule
